// File: rtl/sram_slot_arbiter_pkg.sv
// Shared types and constants for the SRAM time-slot arbiter.
// Slot map per 16-cycle frame: 0 video, 1 CPU (DMA fallback), 2 video, 3 DMA (CPU fallback).
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 19;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        CYC_ADDR   = 2'd0,
        CYC_STROBE = 2'd1,
        CYC_SAMPLE = 2'd2,
        CYC_TURN   = 2'd3
    } slot_cyc_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_STROBE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_TURN   = 3'd4
    } acc_state_e;

    localparam logic [1:0] SLOT_VID0 = 2'd0;
    localparam logic [1:0] SLOT_CPU  = 2'd1;
    localparam logic [1:0] SLOT_VID1 = 2'd2;
    localparam logic [1:0] SLOT_DMA  = 2'd3;

endpackage

// File: rtl/sram_slot_arbiter_seq.sv
// Frame phase sequencer: 4-bit phase counter locked to slot_sync, plus
// one-hot slot-cycle strobes for the arbiter core.
module sram_slot_seq
    import sram_arb_pkg::*;
(
    input  logic       ck16,
    input  logic       reset,
    input  logic       slot_sync,
    output logic [3:0] ph,
    output logic [1:0] slot,
    output logic       cyc0,
    output logic       cyc1,
    output logic       cyc2,
    output logic       cyc3
);

    logic [3:0] ph_q;
    logic [3:0] ph_d;

    // Advance the phase; a sync pulse makes the following cycle phase 0
    always_comb begin
        ph_d = ph_q + 4'd1;
        if (slot_sync) begin
            ph_d = 4'd0;
        end
    end

    // Phase register
    always_ff @(posedge ck16) begin
        if (reset) begin
            ph_q <= 4'd0;
        end else begin
            ph_q <= ph_d;
        end
    end

    assign ph   = ph_q;
    assign slot = ph_q[3:2];
    assign cyc0 = (ph_q[1:0] == CYC_ADDR);
    assign cyc1 = (ph_q[1:0] == CYC_STROBE);
    assign cyc2 = (ph_q[1:0] == CYC_SAMPLE);
    assign cyc3 = (ph_q[1:0] == CYC_TURN);

endmodule

// File: rtl/sram_slot_arbiter.sv
// Time-slot arbiter for the shared 8-bit SRAM (video / Z80 CPU / DMA).
// Optional feature macro: SRAM_ARB_DMA_EN (DMA port present). When undefined the
// DMA inputs are ignored, dma_ack/dma_rdata stay 0 and slot 3 serves the CPU only.
// All SRAM pins are registered: the owner picked in slot cycle 0 puts address and
// write data on the bus from cycle 1, WE# is low for cycle 1 only, read data is
// captured at the end of cycle 2 and the ack/valid strobe shows in cycle 3.
module sram_slot_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              ck16,
    input  logic              reset,
    input  logic              slot_sync,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [7:0]        vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic [7:0]        dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] sram_a,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_we_n
);

    logic [3:0] ph;
    logic [1:0] slot;
    logic       cyc0, cyc1, cyc2, cyc3;
    logic       abort;

    sram_slot_seq u_seq (
        .ck16      (ck16),
        .reset     (reset),
        .slot_sync (slot_sync),
        .ph        (ph),
        .slot      (slot),
        .cyc0      (cyc0),
        .cyc1      (cyc1),
        .cyc2      (cyc2),
        .cyc3      (cyc3)
    );

    // A sync at phase 15 coincides with the natural wrap and must not kill anything
    assign abort = slot_sync & (ph != 4'hF);

    logic              dma_req_i;
    logic              dma_we_i;
    logic [ADDR_W-1:0] dma_addr_i;
    logic [7:0]        dma_wdata_i;

`ifdef SRAM_ARB_DMA_EN
    assign dma_req_i   = dma_req;
    assign dma_we_i    = dma_we;
    assign dma_addr_i  = dma_addr;
    assign dma_wdata_i = dma_wdata;
`else
    logic unused_dma;
    assign unused_dma  = ^{dma_req, dma_we, dma_addr, dma_wdata};
    assign dma_req_i   = 1'b0;
    assign dma_we_i    = 1'b0;
    assign dma_addr_i  = '0;
    assign dma_wdata_i = 8'h00;
`endif

    owner_e            sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_wdata;

    // Owner candidate for the current slot; video slots never fall through to CPU/DMA
    always_comb begin
        sel = OWN_NONE;
        case (slot)
            SLOT_VID0, SLOT_VID1: begin
                if (vid_req) sel = OWN_VID;
            end
            SLOT_CPU: begin
                if (cpu_req)        sel = OWN_CPU;
                else if (dma_req_i) sel = OWN_DMA;
            end
            default: begin
                if (dma_req_i)      sel = OWN_DMA;
                else if (cpu_req)   sel = OWN_CPU;
            end
        endcase
    end

    // Request fields of the candidate owner (video is always a read)
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = 8'h00;
        case (sel)
            OWN_VID: sel_addr = vid_addr;
            OWN_CPU: begin
                sel_we    = cpu_we;
                sel_addr  = cpu_addr;
                sel_wdata = cpu_wdata;
            end
            OWN_DMA: begin
                sel_we    = dma_we_i;
                sel_addr  = dma_addr_i;
                sel_wdata = dma_wdata_i;
            end
            default: ;
        endcase
    end

    acc_state_e        st_q, st_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [7:0]        dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic              we_n_q, we_n_d;
    logic [7:0]        vid_data_q, vid_data_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        dma_rdata_q, dma_rdata_d;
    logic              vid_valid_q, vid_valid_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;

    // State register; phase 0 follows reset, so the FSM restarts in an address cycle
    always_ff @(posedge ck16) begin
        if (reset) begin
            st_q <= ST_ADDR;
        end else begin
            st_q <= st_d;
        end
    end

    // Next state: walk the slot cycles, re-enter ADDR at each slot boundary or after an abort
    always_comb begin
        st_d = ST_IDLE;
        if (abort) begin
            st_d = ST_ADDR;
        end else begin
            case (st_q)
                ST_ADDR:   st_d = (cyc0 && sel != OWN_NONE) ? ST_STROBE : ST_IDLE;
                ST_STROBE: st_d = cyc1 ? ST_SAMPLE : ST_IDLE;
                ST_SAMPLE: st_d = cyc2 ? ST_TURN : ST_IDLE;
                ST_TURN:   st_d = cyc3 ? ST_ADDR : ST_IDLE;
                default:   st_d = cyc3 ? ST_ADDR : ST_IDLE;
            endcase
        end
    end

    // Next values of the registered bus pins, read-data holders and strobes
    always_comb begin
        owner_d     = owner_q;
        we_d        = we_q;
        a_d         = a_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;
        we_n_d      = 1'b1;
        vid_data_d  = vid_data_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        vid_valid_d = 1'b0;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        if (abort) begin
            owner_d = OWN_NONE;
            dq_oe_d = 1'b0;
        end else begin
            case (st_q)
                ST_ADDR: begin
                    if (cyc0 && sel != OWN_NONE) begin
                        owner_d = sel;
                        we_d    = sel_we;
                        a_d     = sel_addr;
                        dq_oe_d = sel_we;
                        we_n_d  = ~sel_we;
                        if (sel_we) dq_o_d = sel_wdata;
                    end
                end
                ST_SAMPLE: begin
                    if (cyc2) begin
                        dq_oe_d = 1'b0;
                        case (owner_q)
                            OWN_VID: begin
                                vid_data_d  = sram_dq_i;
                                vid_valid_d = 1'b1;
                            end
                            OWN_CPU: begin
                                if (!we_q) cpu_rdata_d = sram_dq_i;
                                cpu_ack_d = 1'b1;
                            end
                            OWN_DMA: begin
                                if (!we_q) dma_rdata_d = sram_dq_i;
                                dma_ack_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge ck16) begin
        if (reset) begin
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            a_q         <= '0;
            dq_o_q      <= 8'h00;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            vid_data_q  <= 8'h00;
            cpu_rdata_q <= 8'h00;
            dma_rdata_q <= 8'h00;
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            we_q        <= we_d;
            a_q         <= a_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            vid_data_q  <= vid_data_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            vid_valid_q <= vid_valid_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
        end
    end

    assign sram_a     = a_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_we_n  = we_n_q;
    assign vid_data   = vid_data_q;
    assign vid_valid  = vid_valid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_wait   = cpu_req & ~cpu_ack_q;
    assign dma_rdata  = dma_rdata_q;
    assign dma_ack    = dma_ack_q;

endmodule

// File: doc/sram_slot_arbiter.md
# sram_slot_arbiter

Time-slot arbiter sharing the single external 8-bit SRAM between three requesters: video fetch, Z80 CPU and a loader/DMA port. A 16-cycle frame, locked to the gate-array sequencer by `slot_sync`, is split into four 4-cycle slots. The two video slots are fixed and deterministic; the two CPU slots are shared with DMA under fixed priority. Sits between the gate array/CPU glue and the SRAM pins in the top level.

## Interface
- `ADDR_W`, 19: SRAM address width (512 KB).
- `ck16`  in  1  16 MHz system clock.
- `reset`  in  1  synchronous reset, active-high.
- `slot_sync`  in  1  one-cycle pulse; the cycle after it is phase 0.
- `vid_req`  in  1  video wants the current video slot.
- `vid_addr`  in  ADDR_W  video fetch address.
- `vid_data`  out  8  fetched video byte.
- `vid_valid`  out  1  one-cycle strobe: `vid_data` updated.
- `cpu_req`, `cpu_we`  in  1  CPU access request (level) and write flag.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_rdata`  out  8  CPU read data.
- `cpu_ack`  out  1  one-cycle completion strobe.
- `cpu_wait`  out  1  `cpu_req & ~cpu_ack` (combinational), for Z80 WAIT.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ack`: same widths and semantics as the CPU port.
- `sram_a`  out  ADDR_W  SRAM address.
- `sram_dq_o`  out  8  write data.
- `sram_dq_oe`  out  1  data-bus drive enable.
- `sram_dq_i`  in  8  read data.
- `sram_we_n`  out  1  write strobe, active-low.

## Operation
- 4-bit phase counter `ph`; slot = `ph[3:2]`, slot cycle = `ph[1:0]`.
- Slot 0: video. Slot 1: CPU, DMA if CPU idle. Slot 2: video. Slot 3: DMA, CPU if DMA idle.
- Owner is chosen at slot cycle 0 from the request levels sampled that cycle. No requester means the slot is idle.
- An unused video slot is never given to CPU/DMA, so video timing stays fixed.
- Per-slot state machine IDLE→ADDR→STROBE→SAMPLE→TURN:
  - ADDR (c0): latch owner; drive `sram_a`. For a write, also drive `sram_dq_o` and set `sram_dq_oe`=1.
  - STROBE (c1): write → `sram_we_n`=0.
  - SAMPLE (c2): write → `sram_we_n`=1. Read → capture `sram_dq_i` into the owner's rdata register.
  - TURN (c3): `sram_dq_oe`=0; pulse the owner's ack or `vid_valid`.
- Requester holds addr/we/wdata stable from request until ack. It drops `req` the cycle after ack, or the next eligible slot starts a new access.
- A started access always completes and acks, even if `req` drops mid-slot.
- Video never writes.

## Timing
- Reset values: `sram_we_n`=1, `sram_dq_oe`=0, `sram_a`=0, `sram_dq_o`=0; all rdata/`vid_data`=0; acks and `vid_valid`=0; `ph`=0.
- Read latency: ack asserts 3 cycles after the owning slot's c0. Data is valid in the same cycle as ack and holds until the next access by that port.
- Worst-case CPU wait with DMA busy: CPU gets slot 1 in every frame, so the maximum is 15 cycles from request to slot start.
- Simultaneous CPU and DMA requests: slot 1 goes to CPU, slot 3 to DMA; neither starves.
- `slot_sync` mid-frame:
  - `ph` forced to 0 the next cycle; any in-flight access is aborted: `sram_we_n`=1 and `sram_dq_oe`=0 immediately, no ack issued.
  - The aborted requester still has `req` high and retries. An aborted write may have been partially committed; this is acceptable because the retry rewrites the same byte.
- `slot_sync` exactly at `ph`=15 is a no-op (natural wrap).
- Reset mid-access: same as abort, plus everything returns to reset values.
- `ph` wraps 15→0.

## Configuration
- `SRAM_ARB_DMA_EN` defined: DMA port present; arbitration as above.
- Undefined: DMA logic removed; `dma_ack`=0 and `dma_rdata`=0 constant; slot 3 serves CPU only.

## Structure
- Package `sram_arb_pkg`: owner enum (`OWN_NONE`, `OWN_VID`, `OWN_CPU`, `OWN_DMA`), slot-cycle enum, slot-map constants, default `ADDR_W`.
- One sub-module, `sram_slot_seq`: phase counter with `slot_sync`/`reset` handling; outputs `ph`, `slot`, and per-cycle strobes. The arbiter core consumes these strobes.

## Test plan
- Reset, then a `slot_sync` pulse, video reading 0x04000 with SRAM model holding 0xA5 there → `vid_valid` at `ph`=3, `vid_data`=0xA5; `sram_we_n` high throughout.
- CPU writes 0x3C to 0x0C000, then reads it back → `sram_we_n` low only at slot-1 c1; `cpu_ack` at `ph`=7 both times; `cpu_rdata`=0x3C.
- CPU and DMA request together at `ph`=0 → CPU acked at `ph`=7, DMA acked at `ph`=15, no conflicting bus drive.
- `vid_req` low, CPU requesting at `ph`=0 → slot 0 idle; CPU served in slot 1, not slot 0.
- `slot_sync` pulsed at `ph`=5 during a CPU write → `sram_we_n`=1 the next cycle, no ack; write retried and acked at the new `ph`=7.
- Build without `SRAM_ARB_DMA_EN` and hold `dma_req`=1 → `dma_ack` never asserts; CPU acked in slot 3 when requested at `ph`=8.
